// File: rtl/axil_arbiter_rd.sv
// axil_arbiter_rd: round-robin N:1 AXI-Lite read arbiter with one transaction in flight.
// Optional macro AXIL_ADDR_CHECK_EN answers out-of-window addresses locally (rdata all ones, rresp 2'b11).

package axil_pkg;
  localparam int unsigned AXI_ADDR_WIDTH = 32;
  localparam int unsigned AXI_DATA_WIDTH = 32;
endpackage

module axil_arbiter_rd
  import axil_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 4,
  parameter logic [AXI_ADDR_WIDTH-1:0] SLV_BASE = 32'h0000_0000,
  parameter logic [AXI_ADDR_WIDTH-1:0] SLV_MASK = 32'hFFFF_0000,
  localparam int unsigned GW = $clog2(NUM_MASTERS)
) (
  input  logic                                  aclk,
  input  logic                                  areset,
  input  logic [NUM_MASTERS*AXI_ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [NUM_MASTERS-1:0]                s_axil_arvalid,
  output logic [NUM_MASTERS-1:0]                s_axil_arready,
  output logic [NUM_MASTERS*AXI_DATA_WIDTH-1:0] s_axil_rdata,
  output logic [NUM_MASTERS*2-1:0]              s_axil_rresp,
  output logic [NUM_MASTERS-1:0]                s_axil_rvalid,
  input  logic [NUM_MASTERS-1:0]                s_axil_rready,
  output logic [AXI_ADDR_WIDTH-1:0]             m_axil_araddr,
  output logic                                  m_axil_arvalid,
  input  logic                                  m_axil_arready,
  input  logic [AXI_DATA_WIDTH-1:0]             m_axil_rdata,
  input  logic [1:0]                            m_axil_rresp,
  input  logic                                  m_axil_rvalid,
  output logic                                  m_axil_rready,
  output logic [GW-1:0]                         grant_id
);

  localparam int unsigned AW = AXI_ADDR_WIDTH;
  localparam int unsigned DW = AXI_DATA_WIDTH;

  if (NUM_MASTERS < 2 || NUM_MASTERS > 16) begin : g_bad_num_masters
    $error("axil_arbiter_rd: NUM_MASTERS must be in 2..16");
  end
  if ((SLV_BASE & ~SLV_MASK) != '0) begin : g_bad_slv_base
    $error("axil_arbiter_rd: SLV_BASE has bits outside SLV_MASK");
  end

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    M_AR,
    M_R,
    S_R
`ifdef AXIL_ADDR_CHECK_EN
    , ERR
`endif
  } state_t;

  state_t        state;
  logic [GW-1:0] last_grant;
  logic [GW-1:0] winner;
  logic          found;
  int unsigned   idx;

  logic [AW-1:0] araddr_arr [NUM_MASTERS];
  logic [DW-1:0] rdata_q    [NUM_MASTERS];
  logic [1:0]    rresp_q    [NUM_MASTERS];

  // Per-master views of the flat slave-side buses.
  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_slice
    assign araddr_arr[i]            = s_axil_araddr[i*AW +: AW];
    assign s_axil_rdata[i*DW +: DW] = rdata_q[i];
    assign s_axil_rresp[i*2 +: 2]   = rresp_q[i];
  end

  // Round-robin pick: first requester after last_grant, wrapping.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
      idx = (32'(last_grant) + k) % NUM_MASTERS;
      if (!found && s_axil_arvalid[GW'(idx)]) begin
        winner = GW'(idx);
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state          <= IDLE;
      last_grant     <= GW'(NUM_MASTERS - 1);
      grant_id       <= '0;
      s_axil_arready <= '0;
      s_axil_rvalid  <= '0;
      m_axil_araddr  <= '0;
      m_axil_arvalid <= 1'b0;
      m_axil_rready  <= 1'b0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
        rdata_q[i] <= '0;
        rresp_q[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (|s_axil_arvalid) begin
            grant_id               <= winner;
            s_axil_arready[winner] <= 1'b1;
            state                  <= GRANT;
          end
        end
        GRANT: begin
          // The granted master holds arvalid, so the AR handshake completes on this edge.
          s_axil_arready <= '0;
`ifdef AXIL_ADDR_CHECK_EN
          if ((araddr_arr[grant_id] & SLV_MASK) != SLV_BASE) begin
            state <= ERR;
          end else begin
            m_axil_araddr <= araddr_arr[grant_id];
            state         <= M_AR;
          end
`else
          m_axil_araddr <= araddr_arr[grant_id];
          state         <= M_AR;
`endif
        end
        M_AR: begin
          if (m_axil_arvalid && m_axil_arready) begin
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b1;
            state          <= M_R;
          end else begin
            m_axil_arvalid <= 1'b1;
          end
        end
        M_R: begin
          if (m_axil_rvalid) begin
            rdata_q[grant_id]       <= m_axil_rdata;
            rresp_q[grant_id]       <= m_axil_rresp;
            s_axil_rvalid[grant_id] <= 1'b1;
            m_axil_rready           <= 1'b0;
            state                   <= S_R;
          end
        end
        S_R: begin
          if (s_axil_rready[grant_id]) begin
            s_axil_rvalid     <= '0;
            rdata_q[grant_id] <= '0;
            rresp_q[grant_id] <= '0;
            last_grant        <= grant_id;
            state             <= IDLE;
          end
        end
`ifdef AXIL_ADDR_CHECK_EN
        ERR: begin
          rdata_q[grant_id]       <= '1;
          rresp_q[grant_id]       <= 2'b11;
          s_axil_rvalid[grant_id] <= 1'b1;
          state                   <= S_R;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_arbiter_rd.sv
// tb_axil_arbiter_rd: directed bench for axil_arbiter_rd with 4 masters and a scripted downstream slave.
// Covers AR latency, round-robin order, backpressure stability, address check and mid-transaction reset.

module tb_axil_arbiter_rd;

  logic          clk = 1'b0;
  logic          areset;
  logic [127:0]  s_axil_araddr;
  logic [3:0]    s_axil_arvalid;
  logic [3:0]    s_axil_arready;
  logic [127:0]  s_axil_rdata;
  logic [7:0]    s_axil_rresp;
  logic [3:0]    s_axil_rvalid;
  logic [3:0]    s_axil_rready;
  logic [31:0]   m_axil_araddr;
  logic          m_axil_arvalid;
  logic          m_axil_arready;
  logic [31:0]   m_axil_rdata;
  logic [1:0]    m_axil_rresp;
  logic          m_axil_rvalid;
  logic          m_axil_rready;
  logic [1:0]    grant_id;

  logic [31:0]   ar_addr [4];
  logic [31:0]   rd_v    [4];
  logic [1:0]    rr_v    [4];

  int total = 0;
  int bad   = 0;
  int ar_hs = 0;
  int r_hs  = 0;
  int order_q [$];

  logic [31:0] d [4];
  logic [1:0]  r [4];
  logic [31:0] a [4];
  int          lat;
  logic        seen;
  logic        acc;
  int          n;
  int          ar_hs0;
  int          r_hs0;

  axil_arbiter_rd dut (
    .aclk           (clk),
    .areset         (areset),
    .s_axil_araddr  (s_axil_araddr),
    .s_axil_arvalid (s_axil_arvalid),
    .s_axil_arready (s_axil_arready),
    .s_axil_rdata   (s_axil_rdata),
    .s_axil_rresp   (s_axil_rresp),
    .s_axil_rvalid  (s_axil_rvalid),
    .s_axil_rready  (s_axil_rready),
    .m_axil_araddr  (m_axil_araddr),
    .m_axil_arvalid (m_axil_arvalid),
    .m_axil_arready (m_axil_arready),
    .m_axil_rdata   (m_axil_rdata),
    .m_axil_rresp   (m_axil_rresp),
    .m_axil_rvalid  (m_axil_rvalid),
    .m_axil_rready  (m_axil_rready),
    .grant_id       (grant_id)
  );

  always #5 clk = ~clk;

  for (genvar i = 0; i < 4; i++) begin : g_view
    assign s_axil_araddr[i*32 +: 32] = ar_addr[i];
    assign rd_v[i] = s_axil_rdata[i*32 +: 32];
    assign rr_v[i] = s_axil_rresp[i*2 +: 2];
  end

  always @(posedge clk) begin
    if (m_axil_arvalid && m_axil_arready) ar_hs <= ar_hs + 1;
    if (|(s_axil_rvalid & s_axil_rready)) r_hs <= r_hs + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic master_read(input int m, input logic [31:0] addr, input int rr_wait,
                             output logic [31:0] data, output logic [1:0] resp);
    logic [1:0] mi;
    int         cnt;
    logic       stable;
    logic       others;
    mi = 2'(m);
    ar_addr[mi] = addr;
    s_axil_arvalid[mi] = 1'b1;
    cnt = 0;
    while (s_axil_arready[mi] !== 1'b1 && cnt < 400) begin @(negedge clk); cnt++; end
    check("arready", 64'(s_axil_arready[mi]), 64'(1));
    order_q.push_back(m);
    check("grant_id", 64'(grant_id), 64'(mi));
    @(negedge clk);
    s_axil_arvalid[mi] = 1'b0;
    cnt = 0;
    while (s_axil_rvalid[mi] !== 1'b1 && cnt < 400) begin @(negedge clk); cnt++; end
    check("rvalid", 64'(s_axil_rvalid[mi]), 64'(1));
    others = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (j != m)
        others = others | s_axil_rvalid[2'(j)] | s_axil_arready[2'(j)] | (|rd_v[2'(j)]) | (|rr_v[2'(j)]);
    end
    check("others_quiet", 64'(others), 64'(0));
    data   = rd_v[mi];
    resp   = rr_v[mi];
    stable = 1'b1;
    for (int i = 0; i < rr_wait; i++) begin
      @(negedge clk);
      if (s_axil_rvalid[mi] !== 1'b1 || rd_v[mi] !== data || rr_v[mi] !== resp) stable = 1'b0;
    end
    if (rr_wait > 0) check("r_stable", 64'(stable), 64'(1));
    s_axil_rready[mi] = 1'b1;
    @(negedge clk);
    s_axil_rready[mi] = 1'b0;
    check("rvalid_drop", 64'(s_axil_rvalid[mi]), 64'(0));
  endtask

  task automatic slave_serve(input int ar_wait, input int r_wait, input logic use_fixed,
                             input logic [31:0] fdata, input logic [1:0] fresp,
                             output logic [31:0] addr_seen);
    int   cnt;
    logic stable;
    cnt = 0;
    while (m_axil_arvalid !== 1'b1 && cnt < 400) begin @(negedge clk); cnt++; end
    check("slv_ar_seen", 64'(m_axil_arvalid), 64'(1));
    addr_seen = m_axil_araddr;
    stable = 1'b1;
    for (int i = 0; i < ar_wait; i++) begin
      @(negedge clk);
      if (m_axil_arvalid !== 1'b1 || m_axil_araddr !== addr_seen) stable = 1'b0;
    end
    if (ar_wait > 0) check("ar_stable", 64'(stable), 64'(1));
    m_axil_arready = 1'b1;
    @(negedge clk);
    m_axil_arready = 1'b0;
    check("m_arvalid_drop", 64'(m_axil_arvalid), 64'(0));
    check("m_rready_up", 64'(m_axil_rready), 64'(1));
    repeat (r_wait) @(negedge clk);
    m_axil_rdata  = use_fixed ? fdata : (addr_seen ^ 32'h5A5A_5A5A);
    m_axil_rresp  = use_fixed ? fresp : 2'b00;
    m_axil_rvalid = 1'b1;
    cnt = 0;
    while (m_axil_rready !== 1'b1 && cnt < 400) begin @(negedge clk); cnt++; end
    @(negedge clk);
    m_axil_rvalid = 1'b0;
    check("r_latency", 64'(|s_axil_rvalid), 64'(1));
    check("m_rready_drop", 64'(m_axil_rready), 64'(0));
  endtask

  initial begin
    areset = 1'b1;
    s_axil_arvalid = '0;
    s_axil_rready  = '0;
    m_axil_arready = 1'b0;
    m_axil_rdata   = '0;
    m_axil_rresp   = '0;
    m_axil_rvalid  = 1'b0;
    for (int i = 0; i < 4; i++) ar_addr[i] = '0;
    #1;
    check("rst_outputs", 64'(|{s_axil_arready, s_axil_rvalid, s_axil_rdata, s_axil_rresp,
                               m_axil_araddr, m_axil_arvalid, m_axil_rready}), 64'(0));
    check("rst_grant_id", 64'(grant_id), 64'(0));
    repeat (2) @(negedge clk);
    areset = 1'b0;
    @(negedge clk);

    // All four request at once right after reset: served 0,1,2,3.
    order_q.delete();
    fork
      master_read(0, 32'h0000_0100, 0, d[0], r[0]);
      master_read(1, 32'h0000_0104, 0, d[1], r[1]);
      master_read(2, 32'h0000_0108, 0, d[2], r[2]);
      master_read(3, 32'h0000_010C, 0, d[3], r[3]);
      begin
        for (int k = 0; k < 4; k++) slave_serve(0, 1, 1'b0, 32'h0, 2'b00, a[k]);
      end
    join
    check("rr_count", 64'(order_q.size()), 64'(4));
    for (int k = 0; k < 4; k++) begin
      check("rr_order", 64'(order_q[k]), 64'(k));
      check("rr_data", 64'(d[k]), 64'((32'h0000_0100 + 32'(4 * k)) ^ 32'h5A5A_5A5A));
    end

    // Single master 0: data passthrough and 3-cycle AR latency.
    fork
      master_read(0, 32'h0000_0010, 0, d[0], r[0]);
      slave_serve(0, 0, 1'b1, 32'hCAFE_F00D, 2'b00, a[0]);
      begin
        lat = 0;
        while (m_axil_arvalid !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
      end
    join
    check("single_addr", 64'(a[0]), 64'(32'h0000_0010));
    check("single_data", 64'(d[0]), 64'(32'hCAFE_F00D));
    check("single_resp", 64'(r[0]), 64'(0));
    check("ar_latency", 64'(lat), 64'(3));

    // Masters 3 and 2 together after master 0 was last: 2 wins, then 3.
    order_q.delete();
    fork
      master_read(3, 32'h0000_0200, 0, d[3], r[3]);
      master_read(2, 32'h0000_0204, 0, d[2], r[2]);
      begin
        slave_serve(0, 0, 1'b0, 32'h0, 2'b00, a[0]);
        slave_serve(0, 0, 1'b0, 32'h0, 2'b00, a[1]);
      end
    join
    check("rr2_first", 64'(order_q[0]), 64'(2));
    check("rr2_second", 64'(order_q[1]), 64'(3));
    check("rr2_data3", 64'(d[3]), 64'(32'h0000_0200 ^ 32'h5A5A_5A5A));

    // Backpressure on both sides: one transfer each, stable payloads.
    ar_hs0 = ar_hs;
    r_hs0  = r_hs;
    fork
      master_read(0, 32'h0000_0040, 4, d[0], r[0]);
      slave_serve(5, 3, 1'b1, 32'h1234_5678, 2'b10, a[0]);
    join
    check("bp_addr", 64'(a[0]), 64'(32'h0000_0040));
    check("bp_data", 64'(d[0]), 64'(32'h1234_5678));
    check("bp_resp", 64'(r[0]), 64'(2'b10));
    check("bp_ar_once", 64'(ar_hs - ar_hs0), 64'(1));
    check("bp_r_once", 64'(r_hs - r_hs0), 64'(1));

`ifdef AXIL_ADDR_CHECK_EN
    seen = 1'b0;
    fork
      master_read(0, 32'h0001_0000, 0, d[0], r[0]);
      begin
        for (int i = 0; i < 30; i++) begin
          @(negedge clk);
          if (m_axil_arvalid) seen = 1'b1;
        end
      end
    join
    check("err_data", 64'(d[0]), 64'(32'hFFFF_FFFF));
    check("err_resp", 64'(r[0]), 64'(2'b11));
    check("err_no_down", 64'(seen), 64'(0));
`else
    fork
      master_read(0, 32'h0001_0000, 0, d[0], r[0]);
      slave_serve(0, 0, 1'b0, 32'h0, 2'b00, a[0]);
    join
    check("fwd_addr", 64'(a[0]), 64'(32'h0001_0000));
    check("fwd_data", 64'(d[0]), 64'(32'h0001_0000 ^ 32'h5A5A_5A5A));
`endif

    // Reset while waiting for downstream R: abandon, ignore late rvalid, master 0 first after.
    ar_addr[2] = 32'h0000_0024;
    s_axil_arvalid[2] = 1'b1;
    n = 0;
    while (s_axil_arready[2] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    s_axil_arvalid[2] = 1'b0;
    n = 0;
    while (m_axil_arvalid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("pre_rst_araddr", 64'(m_axil_araddr), 64'(32'h0000_0024));
    m_axil_arready = 1'b1;
    @(negedge clk);
    m_axil_arready = 1'b0;
    check("pre_rst_rready", 64'(m_axil_rready), 64'(1));
    areset = 1'b1;
    #1;
    check("midrst_outputs", 64'(|{s_axil_arready, s_axil_rvalid, s_axil_rdata, s_axil_rresp,
                                  m_axil_araddr, m_axil_arvalid, m_axil_rready}), 64'(0));
    check("midrst_grant_id", 64'(grant_id), 64'(0));
    @(negedge clk);
    areset = 1'b0;
    r_hs0 = r_hs;
    m_axil_rdata  = 32'hDEAD_BEEF;
    m_axil_rvalid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      acc = acc | (|s_axil_rvalid) | m_axil_rready | m_axil_arvalid;
    end
    m_axil_rvalid = 1'b0;
    check("late_r_ignored", 64'(acc), 64'(0));
    check("late_r_no_xfer", 64'(r_hs - r_hs0), 64'(0));

    order_q.delete();
    fork
      master_read(1, 32'h0000_0304, 0, d[1], r[1]);
      master_read(0, 32'h0000_0300, 0, d[0], r[0]);
      begin
        slave_serve(0, 0, 1'b0, 32'h0, 2'b00, a[0]);
        slave_serve(0, 0, 1'b0, 32'h0, 2'b00, a[1]);
      end
    join
    check("post_rst_first", 64'(order_q[0]), 64'(0));
    check("post_rst_addr0", 64'(a[0]), 64'(32'h0000_0300));
    check("post_rst_data1", 64'(d[1]), 64'(32'h0000_0304 ^ 32'h5A5A_5A5A));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axil_arbiter_rd.md
AXIL_ARBITER_RD -- requirements
Module: axil_arbiter_rd

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 4, number of requesting AXI-Lite read masters (2..16).
REQ-002 SHALL have parameter SLV_BASE, default 32'h0000_0000, base address of the downstream slave window.
REQ-003 SHALL have parameter SLV_MASK, default 32'hFFFF_0000, address bits compared against SLV_BASE.
REQ-004 SHALL take AXI_ADDR_WIDTH and AXI_DATA_WIDTH from axil_pkg.
REQ-005 SHALL have one clock and an asynchronous, active-high reset.
REQ-006 aclk  input  1  clock; all state changes on rising edge.
REQ-007 areset  input  1  asynchronous active-high reset.
REQ-008 s_axil_araddr  input  NUM_MASTERS*AXI_ADDR_WIDTH  per-master read address, master i at slice i.
REQ-009 s_axil_arvalid / s_axil_arready  input / output  NUM_MASTERS  per-master AR handshake.
REQ-010 s_axil_rdata  output  NUM_MASTERS*AXI_DATA_WIDTH  per-master read data.
REQ-011 s_axil_rresp  output  NUM_MASTERS*2  per-master read response.
REQ-012 s_axil_rvalid / s_axil_rready  output / input  NUM_MASTERS  per-master R handshake.
REQ-013 m_axil_araddr, m_axil_arvalid / m_axil_arready  output, output / input  AXI_ADDR_WIDTH, 1 / 1  downstream AR channel.
REQ-014 m_axil_rdata, m_axil_rresp, m_axil_rvalid / m_axil_rready  input, input, input / output  AXI_DATA_WIDTH, 2, 1 / 1  downstream R channel.
REQ-015 grant_id  output  $clog2(NUM_MASTERS)  index of the master currently served.

Function
REQ-016 SHALL implement FSM states IDLE, GRANT, M_AR, M_R, S_R (plus ERR, see REQ-030); one transaction in flight.
REQ-017 IDLE: when any s_axil_arvalid is high, SHALL select winner g by round-robin, searching from (last_grant+1) mod NUM_MASTERS upward with wrap; register grant_id<=g, s_axil_arready[g]<=1, go GRANT.
REQ-018 GRANT: AR handshake with master g occurs this cycle; SHALL latch araddr slice g, drive s_axil_arready to 0, go M_AR.
REQ-019 M_AR: SHALL drive m_axil_arvalid=1 with latched address, held stable until m_axil_arready=1; then arvalid<=0, m_axil_rready<=1, go M_R.
REQ-020 M_R: on m_axil_rvalid=1 SHALL capture rdata/rresp, drive m_axil_rready<=0, go S_R.
REQ-021 S_R: SHALL assert s_axil_rvalid[g] with captured data/resp, stable until s_axil_rready[g]=1; then rvalid<=0, last_grant<=g, go IDLE.
REQ-022 All handshake outputs SHALL be registered; no combinational valid/ready path between ports.
REQ-023 Non-granted masters SHALL see arready=0, rvalid=0, rdata='0, rresp=2'b00 at all times.
REQ-024 Arvalid of masters arriving while busy SHALL wait; no request SHALL be dropped or duplicated.
REQ-025 Minimum latency: s_axil_arvalid rise to m_axil_arvalid = 3 cycles; m_axil_rvalid to s_axil_rvalid = 1 cycle.
REQ-026 Fairness: with all masters requesting continuously, grants SHALL cycle 0,1,..,NUM_MASTERS-1,0.

Reset
REQ-027 areset SHALL immediately force state IDLE, last_grant=NUM_MASTERS-1 (master 0 highest priority), grant_id=0.
REQ-028 areset SHALL force all outputs to 0: s_axil_arready, s_axil_rvalid, s_axil_rdata, s_axil_rresp, m_axil_araddr, m_axil_arvalid, m_axil_rready.
REQ-029 Reset mid-transaction SHALL abandon the transaction; no response SHALL be issued after release.

Configuration
REQ-030 With AXIL_ADDR_CHECK_EN defined: in GRANT, if (addr & SLV_MASK) != SLV_BASE, SHALL go ERR instead of M_AR; ERR loads rdata='1, rresp=2'b11, goes S_R next cycle; no downstream access.
REQ-031 Without AXIL_ADDR_CHECK_EN: ERR state SHALL be absent; all addresses forwarded downstream unchanged.

Verification
REQ-032 Single master 0, araddr=32'h0000_0010, slave returns rdata=32'hCAFE_F00D rresp=00 -> master 0 receives same; grant_id=0; m_axil_arvalid 3 cycles after arvalid.
REQ-033 Masters 0..3 request simultaneously after reset -> grant order 0,1,2,3; each gets its own slave data.
REQ-034 Slave holds m_axil_arready=0 for 5 cycles, then rvalid; master holds rready=0 for 4 cycles -> address and data stable throughout, one transfer each.
REQ-035 AXIL_ADDR_CHECK_EN, araddr=32'h0001_0000 -> rdata=32'hFFFF_FFFF, rresp=2'b11, m_axil_arvalid never asserted; without macro, address forwarded.
REQ-036 areset asserted in M_R -> all outputs 0 immediately; after release, late slave rvalid ignored, next request from master 0 served first.
